// File: rtl/pe_seq_ctrl.sv
// rtl/pe_seq_ctrl.sv - job sequencer feeding operands to one pe and collecting its results
module pe_seq_ctrl #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_LOAD   = 64,
  parameter int NUM_RES    = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    s_valid,
  input  logic [2*DATA_WIDTH-1:0] s_data,
  output logic                    s_ready,
  output logic                    pe_din_v,
  output logic [2*DATA_WIDTH-1:0] pe_din,
  input  logic                    pe_dout_v,
  input  logic [2*DATA_WIDTH-1:0] pe_dout,
  output logic                    m_valid,
  output logic [2*DATA_WIDTH-1:0] m_data,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err
);

  localparam int LCW = $clog2(NUM_LOAD + 1);
  localparam int RCW = $clog2(NUM_RES + 1);
  localparam int TCW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_LOAD    = 2'd1,
    ST_COLLECT = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  state_t                    state_q;
  logic [LCW-1:0]            load_cnt_q;
  logic [RCW-1:0]            res_cnt_q;
  logic [TCW-1:0]            timer_q;
  logic                      pe_din_v_q;
  logic [2*DATA_WIDTH-1:0]   pe_din_q;
  logic                      m_valid_q;
  logic [2*DATA_WIDTH-1:0]   m_data_q;
  logic                      timeout_err_q;

  // Handshake and status flags decode straight from the state register, so
  // s_ready has no combinational dependence on s_valid.
  assign s_ready     = (state_q == ST_LOAD);
  assign busy        = (state_q == ST_LOAD) || (state_q == ST_COLLECT);
  assign done        = (state_q == ST_DONE);
  assign pe_din_v    = pe_din_v_q;
  assign pe_din      = pe_din_q;
  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign timeout_err = timeout_err_q;

  // Sequencer: state, counters, watchdog and registered data paths.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      load_cnt_q    <= '0;
      res_cnt_q     <= '0;
      timer_q       <= '0;
      pe_din_v_q    <= 1'b0;
      pe_din_q      <= '0;
      m_valid_q     <= 1'b0;
      m_data_q      <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      // Valid strobes are single-cycle unless re-armed below.
      pe_din_v_q <= 1'b0;
      m_valid_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q       <= ST_LOAD;
            load_cnt_q    <= '0;
            res_cnt_q     <= '0;
            timer_q       <= '0;
            timeout_err_q <= 1'b0;
          end
        end
        ST_LOAD: begin
          if (s_valid) begin
            pe_din_v_q <= 1'b1;
            pe_din_q   <= s_data;
            if (load_cnt_q != LCW'(NUM_LOAD)) begin
              load_cnt_q <= load_cnt_q + 1'b1;
            end
            if (load_cnt_q == LCW'(NUM_LOAD - 1)) begin
              state_q <= ST_COLLECT;
            end
          end
        end
        ST_COLLECT: begin
          // A result arriving on the watchdog's last cycle still counts.
          if (pe_dout_v) begin
            m_valid_q <= 1'b1;
            m_data_q  <= pe_dout;
            timer_q   <= '0;
            if (res_cnt_q != RCW'(NUM_RES)) begin
              res_cnt_q <= res_cnt_q + 1'b1;
            end
            if (res_cnt_q == RCW'(NUM_RES - 1)) begin
              state_q <= ST_DONE;
            end
          end else if (timer_q == TCW'(TIMEOUT - 1)) begin
            state_q       <= ST_DONE;
            timeout_err_q <= 1'b1;
          end else if (timer_q != TCW'(TIMEOUT)) begin
            timer_q <= timer_q + 1'b1;
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pe_seq_ctrl.sv
// tb/tb_pe_seq_ctrl.sv - directed self-checking bench for pe_seq_ctrl
module tb_pe_seq_ctrl;

  localparam int DW       = 16;
  localparam int NUM_LOAD = 64;
  localparam int NUM_RES  = 32;
  localparam int TIMEOUT  = 256;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic          s_valid = 1'b0;
  logic [2*DW-1:0] s_data = '0;
  logic          s_ready;
  logic          pe_din_v;
  logic [2*DW-1:0] pe_din;
  logic          pe_dout_v = 1'b0;
  logic [2*DW-1:0] pe_dout = '0;
  logic          m_valid;
  logic [2*DW-1:0] m_data;
  logic          busy;
  logic          done;
  logic          timeout_err;

  int n_checks = 0;
  int n_errors = 0;

  pe_seq_ctrl #(
    .DATA_WIDTH(DW), .NUM_LOAD(NUM_LOAD), .NUM_RES(NUM_RES), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .rst(rst), .start(start),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pe_din_v(pe_din_v), .pe_din(pe_din),
    .pe_dout_v(pe_dout_v), .pe_dout(pe_dout),
    .m_valid(m_valid), .m_data(m_data),
    .busy(busy), .done(done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2*DW-1:0] op_word(input int i);
    return {16'(4 + 3 * i), 16'(2 + 5 * i)};
  endfunction

  function automatic logic [2*DW-1:0] res_word(input int j);
    return {16'hA000 + 16'(j), 16'h5000 + 16'(7 * j)};
  endfunction

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_sready", s_ready, 1);
    check("start_tmo_clr", timeout_err, 0);
  endtask

  // Streams NUM_LOAD words; optional bubbles alternate s_valid every cycle.
  task automatic load_words(input bit bubbles);
    int acc = 0;
    int cyc = 0;
    logic [2*DW-1:0] last = '0;
    while (acc < NUM_LOAD && cyc < 4 * NUM_LOAD) begin
      s_valid = bubbles ? ((cyc % 2) == 0) : 1'b1;
      s_data  = op_word(acc);
      tick();
      if (s_valid) begin
        check("ld_din_v", pe_din_v, 1);
        check("ld_din", pe_din, op_word(acc));
        last = op_word(acc);
        acc++;
      end else begin
        check("ld_gap_v", pe_din_v, 0);
        check("ld_gap_hold", pe_din, last);
      end
      cyc++;
      if (acc < NUM_LOAD) check("ld_sready", s_ready, 1);
    end
    s_valid = 1'b0;
    check("ld_count", acc, NUM_LOAD);
    check("ld_sready_drop", s_ready, 0);
    check("ld_busy", busy, 1);
    tick();
    check("ld_din_v_after", pe_din_v, 0);
  endtask

  // Returns n back-to-back results starting at index base.
  task automatic give_results(input int n, input int base, input bit finishes);
    for (int j = 0; j < n; j++) begin
      pe_dout_v = 1'b1;
      pe_dout   = res_word(base + j);
      tick();
      pe_dout_v = 1'b0;
      check("res_mvalid", m_valid, 1);
      check("res_mdata", m_data, res_word(base + j));
      check("res_done", done, (finishes && j == n - 1) ? 1 : 0);
    end
  endtask

  initial begin
    int k;
    // Reset state
    #2;
    check("rst_sready", s_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_mvalid", m_valid, 0);
    check("rst_dinv", pe_din_v, 0);
    check("rst_tmo", timeout_err, 0);
    tick();
    rst = 1'b0;
    tick();

    // 1. Full job without gaps
    do_start();
    load_words(1'b0);
    give_results(NUM_RES, 0, 1'b1);
    check("t1_done_busy", busy, 0);
    check("t1_tmo", timeout_err, 0);
    tick();
    check("t1_done_pulse", done, 0);
    check("t1_idle_sready", s_ready, 0);

    // 2. Bubbled input
    do_start();
    load_words(1'b1);
    give_results(NUM_RES, 100, 1'b1);
    tick();

    // 3. Stall after 5 results, then abort
    do_start();
    load_words(1'b0);
    give_results(5, 200, 1'b0);
    k = 0;
    while (!done && k < TIMEOUT + 20) begin
      tick();
      k++;
      if (m_valid) check("t3_no_mvalid", m_valid, 0);
    end
    check("t3_abort_cycles", k, TIMEOUT);
    check("t3_tmo_set", timeout_err, 1);
    check("t3_busy", busy, 0);
    tick();
    check("t3_tmo_sticky", timeout_err, 1);
    check("t3_done_low", done, 0);
    tick();
    check("t3_tmo_still", timeout_err, 1);
    do_start();
    load_words(1'b0);
    give_results(NUM_RES, 300, 1'b1);
    tick();

    // 4. Spurious start / pe_dout_v
    pe_dout_v = 1'b1; pe_dout = 32'hDEAD_BEEF;
    tick();
    pe_dout_v = 1'b0;
    check("t4_idle_dout", m_valid, 0);
    check("t4_idle_busy", busy, 0);
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    check("t4_held_start", busy, 1);
    s_valid = 1'b1; s_data = op_word(0); start = 1'b1; pe_dout_v = 1'b1;
    tick();
    s_valid = 1'b0; start = 1'b0; pe_dout_v = 1'b0;
    check("t4_load_dout", m_valid, 0);
    check("t4_load_word0", pe_din, op_word(0));
    // first word consumed above; stream the rest
    for (int i = 1; i < NUM_LOAD; i++) begin
      s_valid = 1'b1; s_data = op_word(i);
      tick();
    end
    s_valid = 1'b0;
    check("t4_collect", s_ready, 0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_collect_start", busy, 1);
    check("t4_collect_sready", s_ready, 0);
    give_results(NUM_RES, 400, 1'b1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("t4_done_start", busy, 0);
    tick();
    check("t4_still_idle", busy, 0);

    // 5. Reset mid-LOAD
    do_start();
    for (int i = 0; i < 10; i++) begin
      s_valid = 1'b1; s_data = op_word(i);
      tick();
    end
    s_valid = 1'b0;
    rst = 1'b1;
    #1;
    check("t5_sready", s_ready, 0);
    check("t5_busy", busy, 0);
    check("t5_dinv", pe_din_v, 0);
    check("t5_din", pe_din, 0);
    check("t5_mvalid", m_valid, 0);
    check("t5_done", done, 0);
    tick();
    rst = 1'b0;
    tick();
    do_start();
    load_words(1'b0);
    give_results(NUM_RES, 500, 1'b1);
    tick();

    // 6. Result on the watchdog's last cycle
    do_start();
    load_words(1'b0);
    give_results(1, 600, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t6_pre_done", done, 0);
    give_results(1, 601, 1'b0);
    check("t6_busy", busy, 1);
    check("t6_tmo", timeout_err, 0);
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("t6_restart", done, 0);
    check("t6_restart_busy", busy, 1);
    give_results(NUM_RES - 2, 602, 1'b1);
    check("t6_tmo_end", timeout_err, 0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
